game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//  Top-level game controller for flappybird. Sequences INITIAL -> PLAY -> LOSE -> INITIAL.
//  Gates pipe motion and flight, owns the score and the 5-slot coin-visibility mask, and
//  generates the game tick and the lose-flash. Sits between the buttons and
//  X_RAM_NOREAD / obstacle_logic / coin_logic / flight_control.
// PARAMETERS
//  TICK_DIV   524288  Clk cycles per game tick (Tick pulse period in PLAY)
//  FLASH_DIV  4194304 Clk cycles between Flash toggles in LOSE
//  LOSE_HOLD  2       Flash toggles required in LOSE before Ack is accepted
//  COIN_PTS   5       score added per collected coin
//  SCORE_MAX  999     score saturation value (3-digit SSD)
// PORTS
//  Clk          in   1   system clock; all logic on its rising edge
//  reset        in   1   asynchronous, active-high reset
//  Start        in   1   raw button level; synchronised internally (2 flops + edge detect)
//  Ack          in   1   raw button level; synchronised internally (2 flops + edge detect)
//  Collide      in   1   1-cycle pulse from obstacle_logic: bird hit a pipe
//  Pipe_Passed  in   1   1-cycle pulse from X_RAM: front pipe left scope, slots shift
//  Coin_Hit     in   1   1-cycle pulse from coin_logic: bird overlaps front coin (slot 0)
//  Q_Initial    out  1   one-hot state flag
//  Q_Play       out  1   one-hot state flag
//  Q_Lose       out  1   one-hot state flag
//  Run_EN       out  1   pipes/flight may advance (= Q_Play)
//  Tick         out  1   1-cycle game tick pulse, PLAY only
//  Flash        out  1   lose-flash level, 0 outside LOSE
//  Show_Coin    out  5   coin visibility per slot; bit 0 = front slot
//  Score        out  10  current score, unsigned binary, saturating
// BEHAVIOUR
//  - Reset: state INITIAL (Q_Initial=1, others 0), Run_EN=0, Tick=0, Flash=0,
//    Show_Coin=5'b00000, Score=0, all counters and synchroniser flops 0.
//  - Button edge: raw input high before edge k -> start_p/ack_p asserted in the cycle after
//    edge k+1; the state change is visible after edge k+2. One pulse per press; holding does not repeat.
//  - INITIAL: Score=0, Show_Coin=0, tick counter=0. start_p -> PLAY; Show_Coin loads 5'b11111
//    on the same edge. ack_p is ignored.
//  - PLAY: tick counter runs 0..TICK_DIV-1; Tick=1 for the cycle when the counter = TICK_DIV-1,
//    and the counter then wraps to 0. Collide -> LOSE on the next edge; Run_EN falls on that
//    same edge. Pulses arriving on the Collide edge are still processed (score and slots update).
//  - Pipe_Passed (PLAY): Show_Coin[i] <= Show_Coin[i+1] for i=0..3; Show_Coin[4] <= 1;
//    Score += 1.
//  - Coin_Hit (PLAY) with Show_Coin[0]=1: Score += COIN_PTS; Show_Coin[0] <= 0.
//    With Show_Coin[0]=0: no effect (a coin scores only once).
//  - Coin_Hit and Pipe_Passed on the same edge: Score += 1 + COIN_PTS, with the coin judged
//    on pre-shift Show_Coin[0]. The shift result wins for all slots.
//  - Score arithmetic: 11-bit intermediate sum, clamped to SCORE_MAX; never wraps.
//  - LOSE: Score and Show_Coin frozen; Tick=0. Flash toggles every FLASH_DIV cycles, and
//    each toggle increments a hold counter that saturates at LOSE_HOLD.
//    ack_p with hold counter = LOSE_HOLD -> INITIAL (Score=0, Show_Coin=0, Flash=0).
//    An earlier ack_p is dropped; a new press is required.
//  - start_p outside INITIAL: ignored. Collide/Pipe_Passed/Coin_Hit outside PLAY: ignored.
//  - Asserting reset in any state returns all outputs to reset values immediately (async).
//  - Illegal state encoding -> INITIAL on the next edge.
// TESTING
//  1 reset, then Start high 3 cycles -> Q_Play=1 after edge 3, Show_Coin=5'b11111, Score=0.
//  2 PLAY, TICK_DIV=4 -> Tick high every 4th cycle; after Collide no Tick and Q_Lose=1 next edge.
//  3 PLAY, Coin_Hit twice, then Pipe_Passed -> Score 5, 5, 6; Show_Coin 11110, 11110, 11111.
//  4 Coin_Hit+Pipe_Passed on the same edge, Show_Coin=11111 -> Score +6, Show_Coin=11111.
//  5 Score=997, Coin_Hit -> Score=999; a further Pipe_Passed keeps 999.
//  6 LOSE, LOSE_HOLD=2, Ack before 2nd toggle -> stays LOSE; Ack after -> INITIAL, Score=0.
//    Reset mid-PLAY -> all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/game_sequencer_if.sv
// game_sequencer_if: button, event-pulse and status bundle between the game sequencer and its neighbours.
interface game_sequencer_if;
    logic       Start;
    logic       Ack;
    logic       Collide;
    logic       Pipe_Passed;
    logic       Coin_Hit;
    logic       Q_Initial;
    logic       Q_Play;
    logic       Q_Lose;
    logic       Run_EN;
    logic       Tick;
    logic       Flash;
    logic [4:0] Show_Coin;
    logic [9:0] Score;
    modport master (
        output Start, Ack, Collide, Pipe_Passed, Coin_Hit,
        input  Q_Initial, Q_Play, Q_Lose, Run_EN, Tick, Flash, Show_Coin, Score
    );
    modport slave (
        input  Start, Ack, Collide, Pipe_Passed, Coin_Hit,
        output Q_Initial, Q_Play, Q_Lose, Run_EN, Tick, Flash, Show_Coin, Score
    );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer: flappybird INITIAL/PLAY/LOSE controller owning score, coin mask, game tick and lose-flash.
module game_sequencer #(
    parameter int TICK_DIV  = 524288,
    parameter int FLASH_DIV = 4194304,
    parameter int LOSE_HOLD = 2,
    parameter int COIN_PTS  = 5,
    parameter int SCORE_MAX = 999
) (
    input  logic             Clk,
    input  logic             reset,
    game_sequencer_if.slave  bus
);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int FW = FLASH_DIV > 1 ? $clog2(FLASH_DIV) : 1;
    localparam int HW = LOSE_HOLD > 0 ? $clog2(LOSE_HOLD + 1) : 1;
    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_LOSE = 2'd2;

    logic [1:0]    state;
    logic [2:0]    start_sync;
    logic [2:0]    ack_sync;
    logic          start_p;
    logic          ack_p;
    logic [TW-1:0] tick_cnt;
    logic [FW-1:0] flash_cnt;
    logic [HW-1:0] hold;
    logic          flash;
    logic [9:0]    score;
    logic [4:0]    show_coin;
    logic          coin;
    logic          tick;
    logic          flash_wrap;
    logic          ack_ok;
    logic [10:0]   sum;
    logic [9:0]    score_nxt;
    logic [4:0]    show_nxt;

    // Two synchroniser flops, the third only remembers the previous level for edge detection
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            start_sync <= '0;
            ack_sync   <= '0;
        end else begin
            start_sync <= {start_sync[1:0], bus.Start};
            ack_sync   <= {ack_sync[1:0], bus.Ack};
        end
    end

    assign start_p = start_sync[1] & ~start_sync[2];
    assign ack_p   = ack_sync[1] & ~ack_sync[2];

    // Coin is judged on the pre-shift front slot; a pipe pass shift overrides the coin clear
    always_comb begin
        coin       = bus.Coin_Hit & show_coin[0];
        sum        = 11'(score) + 11'(bus.Pipe_Passed) + (coin ? 11'(COIN_PTS) : 11'd0);
        score_nxt  = sum > 11'(SCORE_MAX) ? 10'(SCORE_MAX) : sum[9:0];
        show_nxt   = bus.Pipe_Passed ? {1'b1, show_coin[4:1]} : {show_coin[4:1], show_coin[0] & ~coin};
        tick       = state == S_PLAY && tick_cnt == TW'(TICK_DIV - 1);
        flash_wrap = flash_cnt == FW'(FLASH_DIV - 1);
        ack_ok     = ack_p && hold == HW'(LOSE_HOLD);
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state     <= S_INIT;
            tick_cnt  <= '0;
            flash_cnt <= '0;
            hold      <= '0;
            flash     <= 1'b0;
            score     <= '0;
            show_coin <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    state     <= start_p ? S_PLAY : S_INIT;
                    show_coin <= start_p ? 5'b11111 : 5'b00000;
                    score     <= '0;
                    tick_cnt  <= '0;
                    flash_cnt <= '0;
                    hold      <= '0;
                    flash     <= 1'b0;
                end
                S_PLAY: begin
                    state     <= bus.Collide ? S_LOSE : S_PLAY;
                    score     <= score_nxt;
                    show_coin <= show_nxt;
                    tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
                end
                S_LOSE: begin
                    tick_cnt <= '0;
                    if (ack_ok) begin
                        state     <= S_INIT;
                        score     <= '0;
                        show_coin <= '0;
                        flash     <= 1'b0;
                        hold      <= '0;
                        flash_cnt <= '0;
                    end else begin
                        flash_cnt <= flash_wrap ? '0 : flash_cnt + 1'b1;
                        if (flash_wrap) begin
                            flash <= ~flash;
                            hold  <= hold == HW'(LOSE_HOLD) ? hold : hold + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_INIT;
                    flash <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Q_Initial = state == S_INIT;
    assign bus.Q_Play    = state == S_PLAY;
    assign bus.Q_Lose    = state == S_LOSE;
    assign bus.Run_EN    = state == S_PLAY;
    assign bus.Tick      = tick;
    assign bus.Flash     = flash;
    assign bus.Show_Coin = show_coin;
    assign bus.Score     = score;
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: vector table plus hand-written sequences, expectations queued and checked after each edge.
module tb_game_sequencer;
    localparam int TD = 4;
    localparam int FD = 8;
    localparam int LH = 2;
    localparam logic [2:0] QI = 3'b001;
    localparam logic [2:0] QP = 3'b010;
    localparam logic [2:0] QL = 3'b100;

    logic Clk = 1'b0;
    logic reset = 1'b1;
    game_sequencer_if gi();

    game_sequencer #(
        .TICK_DIV(TD), .FLASH_DIV(FD), .LOSE_HOLD(LH), .COIN_PTS(5), .SCORE_MAX(999)
    ) dut (
        .Clk(Clk),
        .reset(reset),
        .bus(gi)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0] q;
        logic [9:0] score;
        logic [4:0] show;
        logic       tick;
        logic       flash;
    } exp_t;

    typedef struct {
        logic       coin;
        logic       pipe;
        logic [9:0] score;
        logic [4:0] show;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   n_vec = 0;
    int   n_miss = 0;
    int   pc = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    task automatic drive(input logic c, input logic p, input logic col, input logic s, input logic a);
        gi.Coin_Hit    = c;
        gi.Pipe_Passed = p;
        gi.Collide     = col;
        gi.Start       = s;
        gi.Ack         = a;
    endtask

    task automatic expect_next(input logic [2:0] q, input logic [9:0] sc, input logic [4:0] sh,
                               input logic tk, input logic fl);
        sb.push_back('{q, sc, sh, tk, fl});
    endtask

    task automatic cycle();
        exp_t e;
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("state", 32'({gi.Q_Lose, gi.Q_Play, gi.Q_Initial}), 32'(e.q));
            chk("run_en", 32'(gi.Run_EN), 32'(e.q[1]));
            chk("score", 32'(gi.Score), 32'(e.score));
            chk("show_coin", 32'(gi.Show_Coin), 32'(e.show));
            chk("tick", 32'(gi.Tick), 32'(e.tick));
            chk("flash", 32'(gi.Flash), 32'(e.flash));
        end
    endtask

    task automatic play_step(input logic c, input logic p, input logic [9:0] sc, input logic [4:0] sh);
        drive(c, p, 1'b0, 1'b0, 1'b0);
        pc++;
        expect_next(QP, sc, sh, pc % TD == TD - 1, 1'b0);
        cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_q"}, 32'({gi.Q_Lose, gi.Q_Play, gi.Q_Initial}), 32'(QI));
        chk({tag, "_run_en"}, 32'(gi.Run_EN), 32'd0);
        chk({tag, "_tick"}, 32'(gi.Tick), 32'd0);
        chk({tag, "_flash"}, 32'(gi.Flash), 32'd0);
        chk({tag, "_show"}, 32'(gi.Show_Coin), 32'd0);
        chk({tag, "_score"}, 32'(gi.Score), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 10'd5,  5'b11110};
        vecs[1] = '{1'b1, 1'b0, 10'd5,  5'b11110};
        vecs[2] = '{1'b0, 1'b1, 10'd6,  5'b11111};
        vecs[3] = '{1'b1, 1'b1, 10'd12, 5'b11111};
        vecs[4] = '{1'b0, 1'b1, 10'd13, 5'b11111};
        vecs[5] = '{1'b0, 1'b0, 10'd13, 5'b11111};
        vecs[6] = '{1'b1, 1'b0, 10'd18, 5'b11110};
        vecs[7] = '{1'b0, 1'b1, 10'd19, 5'b11111};

        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge Clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Start press: PLAY becomes visible after the third edge
        drive(0, 0, 0, 1, 0);
        expect_next(QI, 10'd0, 5'b00000, 1'b0, 1'b0);
        cycle();
        expect_next(QI, 10'd0, 5'b00000, 1'b0, 1'b0);
        cycle();
        expect_next(QP, 10'd0, 5'b11111, 1'b0, 1'b0);
        cycle();
        pc = 0;
        for (int j = 1; j < 8; j++) play_step(1'b0, 1'b0, 10'd0, 5'b11111);

        for (int k = 0; k < 8; k++) play_step(vecs[k].coin, vecs[k].pipe, vecs[k].score, vecs[k].show);

        // 163 coin/pipe pairs add 978, landing on 997
        for (int k = 0; k < 163; k++) begin
            drive(1, 0, 0, 0, 0);
            @(posedge Clk);
            #1;
            drive(0, 1, 0, 0, 0);
            @(posedge Clk);
            #1;
            pc += 2;
        end
        chk("score_997", 32'(gi.Score), 32'd997);
        chk("show_997", 32'(gi.Show_Coin), 32'h1f);
        play_step(1'b1, 1'b0, 10'd999, 5'b11110);
        play_step(1'b0, 1'b1, 10'd999, 5'b11111);

        // Collide with a coin on the same edge: coin still clears slot 0
        drive(1, 0, 1, 0, 0);
        expect_next(QL, 10'd999, 5'b11110, 1'b0, 1'b0);
        cycle();

        for (int i = 1; i <= 20; i++) begin
            drive(i == 6, i == 5, 1'b0, i >= 5 && i <= 7, i <= 7 || (i >= 17 && i <= 19));
            expect_next(i >= 19 ? QI : QL, i >= 19 ? 10'd0 : 10'd999, i >= 19 ? 5'b00000 : 5'b11110,
                        1'b0, i >= 8 && i < 16);
            cycle();
        end

        drive(0, 0, 0, 1, 0);
        expect_next(QI, 10'd0, 5'b00000, 1'b0, 1'b0);
        cycle();
        expect_next(QI, 10'd0, 5'b00000, 1'b0, 1'b0);
        cycle();
        expect_next(QP, 10'd0, 5'b11111, 1'b0, 1'b0);
        cycle();
        drive(1, 0, 0, 0, 0);
        expect_next(QP, 10'd5, 5'b11110, 1'b0, 1'b0);
        cycle();
        drive(0, 0, 0, 0, 0);

        // Asynchronous reset mid-cycle, checked before the next edge
        #3;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(posedge Clk);
        #1;
        reset = 1'b0;
        expect_next(QI, 10'd0, 5'b00000, 1'b0, 1'b0);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
